// File: rtl/ps2_pkg.sv
// ps2_pkg: constants and types shared by the PS/2 keyboard receiver.
//   PS2_EXT / PS2_BRK : prefix byte values folded into event flags
//   EXT_BIT / BRK_BIT : flag positions inside the 10-bit event word
//   ps2_state_e       : frame deserialiser states
package ps2_pkg;

    localparam logic [7:0] PS2_EXT = 8'hE0;
    localparam logic [7:0] PS2_BRK = 8'hF0;

    localparam int EXT_BIT = 9;
    localparam int BRK_BIT = 8;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DATA   = 2'd1,
        ST_PARITY = 2'd2,
        ST_STOP   = 2'd3
    } ps2_state_e;

endpackage

// File: rtl/ps2_rx_frame.sv
// ps2_rx_frame: synchronises the PS/2 lines, detects ps2_clk falling edges
// and deserialises 11-bit frames (start, 8 data LSB-first, parity, stop).
// Ports:
//   clk, rst        system clock, synchronous active-high reset
//   ps2_clk         asynchronous PS/2 clock
//   ps2_data        asynchronous PS/2 data
//   byte_valid      1-cycle pulse, frame with good stop bit completed
//   byte_data[7:0]  received byte, valid while byte_valid is high
module ps2_rx_frame
    import ps2_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 200000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic       byte_valid,
    output logic [7:0] byte_data
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT_CYCLES - 1);

    logic          r_clk_s1;
    logic          r_clk_s2;
    logic          r_clk_prev;
    logic          r_data_s1;
    logic          r_data_s2;
    ps2_state_e    r_state;
    logic [2:0]    r_bit_cnt;
    logic [7:0]    r_shift;
    logic [CW-1:0] r_to_cnt;
    logic          w_fall;

    assign w_fall = r_clk_prev & ~r_clk_s2;

    // Completion is decoded straight from the stop-bit edge so the top can
    // register the event one cycle later without another pipeline stage.
    assign byte_valid = (r_state == ST_STOP) && w_fall && r_data_s2;
    assign byte_data  = r_shift;

    // Synchronisers, edge history, frame FSM and inter-edge timeout.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_clk_s1   <= 1'b1;
            r_clk_s2   <= 1'b1;
            r_clk_prev <= 1'b1;
            r_data_s1  <= 1'b1;
            r_data_s2  <= 1'b1;
            r_state    <= ST_IDLE;
            r_bit_cnt  <= 3'd0;
            r_shift    <= 8'h00;
            r_to_cnt   <= '0;
        end else begin
            r_clk_s1   <= ps2_clk;
            r_clk_s2   <= r_clk_s1;
            r_clk_prev <= r_clk_s2;
            r_data_s1  <= ps2_data;
            r_data_s2  <= r_data_s1;

            case (r_state)
                ST_IDLE: begin
                    if (w_fall && !r_data_s2) begin
                        r_bit_cnt <= 3'd0;
                        r_state   <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (w_fall) begin
                        r_shift   <= {r_data_s2, r_shift[7:1]};
                        r_bit_cnt <= r_bit_cnt + 3'd1;
                        if (r_bit_cnt == 3'd7) begin
                            r_state <= ST_PARITY;
                        end
                    end
                end
                ST_PARITY: begin
                    // Parity is consumed but deliberately not checked.
                    if (w_fall) begin
                        r_state <= ST_STOP;
                    end
                end
                ST_STOP: begin
                    if (w_fall) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase

            // Timeout overrides the FSM update above when it expires.
            if (r_state == ST_IDLE) begin
                r_to_cnt <= '0;
            end else if (w_fall) begin
                r_to_cnt <= '0;
            end else if (r_to_cnt == TO_LAST) begin
                r_to_cnt <= '0;
                r_state  <= ST_IDLE;
            end else begin
                r_to_cnt <= r_to_cnt + {{(CW-1){1'b0}}, 1'b1};
            end
        end
    end

endmodule

// File: rtl/ps2_keyboard.sv
// ps2_keyboard: PS/2 keyboard receiver producing decoded key events.
// Ports:
//   clk, rst        system clock, synchronous active-high reset
//   ps2_clk         asynchronous PS/2 clock
//   ps2_data        asynchronous PS/2 data
//   data_out[9:0]   {extended, break, scan code}, holds until next event
//   ready           1-cycle strobe marking a new data_out
module ps2_keyboard
    import ps2_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 200000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [9:0] data_out,
    output logic       ready
);

    logic       w_byte_valid;
    logic [7:0] w_byte;
    logic       r_ext;
    logic       r_brk;
    logic [9:0] r_data_out;
    logic       r_ready;

    ps2_rx_frame #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_rx (
        .clk       (clk),
        .rst       (rst),
        .ps2_clk   (ps2_clk),
        .ps2_data  (ps2_data),
        .byte_valid(w_byte_valid),
        .byte_data (w_byte)
    );

    assign data_out = r_data_out;
    assign ready    = r_ready;

    // Prefix folding: E0/F0 only arm flags, any other byte emits an event.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ext      <= 1'b0;
            r_brk      <= 1'b0;
            r_data_out <= 10'h000;
            r_ready    <= 1'b0;
        end else begin
            r_ready <= 1'b0;
            if (w_byte_valid) begin
                if (w_byte == PS2_EXT) begin
                    r_ext <= 1'b1;
                end else if (w_byte == PS2_BRK) begin
                    r_brk <= 1'b1;
                end else begin
                    r_data_out[EXT_BIT] <= r_ext;
                    r_data_out[BRK_BIT] <= r_brk;
                    r_data_out[7:0]     <= w_byte;
                    r_ready             <= 1'b1;
                    r_ext               <= 1'b0;
                    r_brk               <= 1'b0;
                end
            end else begin
                r_ready <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_ps2_keyboard.sv
// tb_ps2_keyboard: directed bench for ps2_keyboard with hand-computed events.
module tb_ps2_keyboard;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       ps2_clk = 1'b1;
    logic       ps2_data = 1'b1;
    logic [9:0] data_out;
    logic       ready;

    int n_cmp = 0;
    int n_err = 0;
    int ready_total = 0;
    int base;

    ps2_keyboard #(.TIMEOUT_CYCLES(50)) dut (
        .clk     (clk),
        .rst     (rst),
        .ps2_clk (ps2_clk),
        .ps2_data(ps2_data),
        .data_out(data_out),
        .ready   (ready)
    );

    always #5 clk = ~clk;

    // Counts every cycle in which ready is high.
    always @(negedge clk) begin
        if (ready === 1'b1) ready_total <= ready_total + 1;
    end

    task automatic check(input string tag, input logic [9:0] obs, input logic [9:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One ordinary PS/2 bit: data one cycle ahead, 4 cycles low, 5 high.
    task automatic ps2_bit(input logic b);
        @(negedge clk); ps2_data = b;
        @(negedge clk); ps2_clk = 1'b0;
        repeat (4) @(negedge clk);
        ps2_clk = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    // Stop bit with a latency check: ready must appear two edges after
    // the first clk edge that sees ps2_clk low, not one.
    task automatic ps2_stop(input logic b, input logic exp_rdy, input string tag);
        @(negedge clk); ps2_data = b;
        @(negedge clk); ps2_clk = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check({tag, "_rdy_early"}, {9'd0, ready}, 10'd0);
        @(negedge clk);
        check({tag, "_rdy_lat"}, {9'd0, ready}, {9'd0, exp_rdy});
        @(negedge clk);
        ps2_clk = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic par, input logic stop,
                              input logic exp_rdy, input string tag);
        ps2_bit(1'b0);
        for (int i = 0; i < 8; i++) ps2_bit(b[i]);
        ps2_bit(par);
        ps2_stop(stop, exp_rdy, tag);
        repeat (2) @(negedge clk);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("reset_data", data_out, 10'h000);
        check("reset_ready", {9'd0, ready}, 10'd0);
        rst = 1'b0;
        repeat (3) @(negedge clk);

        // Break code F0 1A
        base = ready_total;
        send_frame(8'hF0, 1'b0, 1'b1, 1'b0, "brk_f0");
        check("brk_f0_cnt", 10'(ready_total - base), 10'd0);
        send_frame(8'h1A, 1'b1, 1'b1, 1'b1, "brk_1a");
        check("brk_cnt", 10'(ready_total - base), 10'd1);
        check("brk_data", data_out, 10'h11A);

        // Make code 1C
        base = ready_total;
        send_frame(8'h1C, 1'b0, 1'b1, 1'b1, "make");
        check("make_cnt", 10'(ready_total - base), 10'd1);
        check("make_data", data_out, 10'h01C);

        // Extended break E0 F0 75, then plain 75
        base = ready_total;
        send_frame(8'hE0, 1'b0, 1'b1, 1'b0, "xb_e0");
        send_frame(8'hF0, 1'b1, 1'b1, 1'b0, "xb_f0");
        check("xb_pre_cnt", 10'(ready_total - base), 10'd0);
        send_frame(8'h75, 1'b0, 1'b1, 1'b1, "xb_75");
        check("xb_cnt", 10'(ready_total - base), 10'd1);
        check("xb_data", data_out, 10'h375);
        send_frame(8'h75, 1'b0, 1'b1, 1'b1, "plain_75");
        check("plain_data", data_out, 10'h075);

        // Repeated break prefix is idempotent
        send_frame(8'hF0, 1'b1, 1'b1, 1'b0, "rep_f0a");
        send_frame(8'hF0, 1'b1, 1'b1, 1'b0, "rep_f0b");
        send_frame(8'h1A, 1'b0, 1'b1, 1'b1, "rep_1a");
        check("rep_data", data_out, 10'h11A);

        // Bad stop bit: frame discarded
        base = ready_total;
        send_frame(8'h1C, 1'b0, 1'b0, 1'b0, "badstop");
        check("badstop_cnt", 10'(ready_total - base), 10'd0);
        check("badstop_data", data_out, 10'h11A);

        // Reset after 5 data bits, then a clean 2B frame
        base = ready_total;
        ps2_bit(1'b0);
        for (int i = 0; i < 5; i++) ps2_bit(1'b1);
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        check("rst_data", data_out, 10'h000);
        repeat (3) @(negedge clk);
        send_frame(8'h2B, 1'b0, 1'b1, 1'b1, "rst_2b");
        check("rst_cnt", 10'(ready_total - base), 10'd1);
        check("rst_2b_data", data_out, 10'h02B);

        // Timeout after 4 data bits, then a full 1D frame
        base = ready_total;
        ps2_bit(1'b0);
        for (int i = 0; i < 4; i++) ps2_bit(1'b0);
        repeat (100) @(negedge clk);
        send_frame(8'h1D, 1'b1, 1'b1, 1'b1, "to_1d");
        check("to_cnt", 10'(ready_total - base), 10'd1);
        check("to_data", data_out, 10'h01D);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
